clk_gate_ctrl: RTL and testbench
================================

// Module: clk_gate_ctrl
// PURPOSE
//  Controller that drives the enable (E) input of a cell_clock_gating ICG.
//  Watches an idle indication from the gated domain and removes its clock after
//  IDLE_CYCLES consecutive idle cycles. Restores the clock on wake request or
//  activity, and acknowledges wake requests only once the gated clock is running.
//  Lives in the free-running clock domain that also feeds the ICG CP input.
// PARAMETERS
//  IDLE_CYCLES  16  consecutive idle cycles before gating (>=1)
//  WAKE_CYCLES  2   cycles gate_en is high before wake_ack / return to RUN (>=1)
//  STAT_W       16  width of gating-event statistics counter
// PORTS
//  clk        in   1       free-running clock; same net as ICG CP
//  rst        in   1       synchronous reset, active-high
//  test_en    in   1       DFT mode; freezes FSM in RUN (ICG TE tied separately)
//  idle_i     in   1       gated domain idle (level, synchronous to clk)
//  wake_req   in   1       wake request level; held high until wake_ack seen
//  wake_ack   out  1       one-cycle pulse: gated clock is running
//  gate_en    out  1       registered enable to ICG E; 1 = clock passes
//  gated_o    out  1       status: 1 while in GATED
//  gate_cnt   out  STAT_W  number of entries into GATED, saturating
// BEHAVIOUR
//  Reset (rst=1 at posedge clk): state=RUN, gate_en=1, wake_ack=0,
//   gated_o=0, idle counter=0, gate_cnt=0, ack_done=0.
//  All outputs registered; gate_en changes only after posedge clk, so it is
//   stable before the ICG latch opens (CP low).
//  States / transitions (evaluated each posedge, priority top-down):
//   any state, test_en=1 -> RUN, counters cleared, gate_en=1.
//   RUN:   idle_i=1 & wake_req=0 -> COUNT, cnt=0.
//   COUNT: idle_i=0 | wake_req=1 -> RUN (activity wins over expiry);
//          cnt==IDLE_CYCLES-1 -> GATED, gate_en=0, gate_cnt+=1 (sat at max);
//          else cnt+=1.
//   GATED: gate_en=0, gated_o=1; wake_req=1 | idle_i=0 -> WAKE, cnt=0,
//          gate_en=1 (registered, takes effect next cycle).
//   WAKE:  gate_en=1; cnt==WAKE_CYCLES-1 -> RUN; else cnt+=1.
//  Latency: idle_i rising in RUN -> gate_en=0 after IDLE_CYCLES+1 posedges.
//   Wake in GATED -> gate_en=1 next cycle; wake_ack WAKE_CYCLES+1 cycles later.
//  Wake handshake: wake_ack pulses one cycle when state==RUN, wake_req=1 and
//   ack_done=0; ack_done set with the pulse, cleared when wake_req=0.
//   Request in RUN/COUNT -> ack next cycle (COUNT returns to RUN first).
//   One ack per request level; wake_req dropped before ack -> no ack.
//  gate_cnt saturates at 2^STAT_W-1; never wraps.
//  Reset mid-gating: next edge state=RUN, gate_en=1 (clock restored).
//  idle_i is assumed synchronous; any CDC synchronizer sits outside.
// STRUCTURE
//  Package clk_gate_pkg: state encoding localparams (RUN=2'd0, COUNT=2'd1,
//   GATED=2'd2, WAKE=2'd3), counter width function clog2.
//  Single module; shared idle/wake counter width clog2(max(IDLE,WAKE)).
//  Bench instantiates clk_gate_ctrl + cell_clock_gating (E=gate_en, CP=clk).
// TESTING
//  T1 reset: rst=1 2 cycles, idle_i=1 -> gate_en=1, gated_o=0, gate_cnt=0.
//  T2 gating: IDLE_CYCLES=16, idle_i=1 held -> gate_en=0 on 17th posedge,
//   ICG Q flat low, gate_cnt=1.
//  T3 idle glitch: idle_i=1 for 15 cycles then 0 one cycle then 1 ->
//   no gating until 16 further idle cycles; gate_cnt unchanged.
//  T4 wake: in GATED raise wake_req -> gate_en=1 next cycle, wake_ack pulse
//   3 cycles after that (WAKE_CYCLES=2), exactly one pulse, state RUN.
//  T5 test mode: in GATED set test_en=1 -> gate_en=1 next cycle; held with
//   idle_i=1 for 100 cycles -> never gates.
//  T6 saturation/reset: STAT_W=2, force 5 gating events -> gate_cnt=3;
//   assert rst while GATED -> gate_en=1, gate_cnt=0 next cycle.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// Shared definitions for the clock-gate controller: FSM state type and a
// constant-evaluable ceil(log2) used to size the idle/wake counter.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        COUNT = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < {32'd0, value}) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cell_clock_gating.sv
// Behavioural integrated clock-gating cell: latch transparent while CP is low,
// so the enable captured for each high phase is glitch-free on Q.
module cell_clock_gating (
    input  logic CP,
    input  logic E,
    input  logic TE,
    output logic Q
);

    logic en_lat_q;

    // Enable latch, open during the low phase of CP.
    always_latch begin
        if (!CP) begin
            en_lat_q <= E | TE;
        end
    end

    assign Q = CP & en_lat_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate controller: drops the ICG enable after IDLE_CYCLES consecutive
// idle cycles, restores it on activity or wake request, and acknowledges a
// wake request once the gated clock has been running for WAKE_CYCLES cycles.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              test_en,
    input  logic              idle_i,
    input  logic              wake_req,
    output logic              wake_ack,
    output logic              gate_en,
    output logic              gated_o,
    output logic [STAT_W-1:0] gate_cnt
);

    localparam int unsigned CNT_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int unsigned CW      = (clog2(CNT_MAX) == 0) ? 1 : clog2(CNT_MAX);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [STAT_W-1:0] gate_cnt_q, gate_cnt_d;
    logic              gate_en_q, gate_en_d;
    logic              gated_q, gated_d;
    logic              wake_ack_q, wake_ack_d;
    logic              ack_done_q, ack_done_d;

    // Next-state, counters and registered-output precomputation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gate_cnt_d = gate_cnt_q;

        // Ack is judged on the current state, so a request raised in COUNT
        // first returns to RUN and is acknowledged on the following edge.
        wake_ack_d = (state_q == RUN) && wake_req && !ack_done_q;
        ack_done_d = wake_req && (ack_done_q || wake_ack_d);

        if (test_en) begin
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (idle_i && !wake_req) begin
                        state_d = COUNT;
                        cnt_d   = '0;
                    end
                end
                COUNT: begin
                    if (!idle_i || wake_req) begin
                        state_d = RUN;
                    end else if (cnt_q == CW'(IDLE_CYCLES - 1)) begin
                        state_d = GATED;
                        if (gate_cnt_q != '1) begin
                            gate_cnt_d = gate_cnt_q + STAT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                GATED: begin
                    if (wake_req || !idle_i) begin
                        state_d = WAKE;
                        cnt_d   = '0;
                    end
                end
                WAKE: begin
                    if (cnt_q == CW'(WAKE_CYCLES - 1)) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end

        gate_en_d = (state_d != GATED);
        gated_d   = (state_d == GATED);
    end

    // State and output registers with synchronous reset to the ungated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            gate_cnt_q <= '0;
            gate_en_q  <= 1'b1;
            gated_q    <= 1'b0;
            wake_ack_q <= 1'b0;
            ack_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gate_cnt_q <= gate_cnt_d;
            gate_en_q  <= gate_en_d;
            gated_q    <= gated_d;
            wake_ack_q <= wake_ack_d;
            ack_done_q <= ack_done_d;
        end
    end

    assign gate_en  = gate_en_q;
    assign gated_o  = gated_q;
    assign wake_ack = wake_ack_q;
    assign gate_cnt = gate_cnt_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Testbench for clk_gate_ctrl: directed scenarios plus randomized traffic
// checked against a streak-counting reference model.
module tb_clk_gate_ctrl;

    localparam int IDLE_CYCLES = 16;
    localparam int WAKE_CYCLES = 2;

    logic        clk;
    logic        rst;
    logic        test_en;
    logic        idle_i;
    logic        wake_req;
    logic        wake_ack;
    logic        gate_en;
    logic        gated_o;
    logic [15:0] gate_cnt;
    logic        wake_ack_s;
    logic        gate_en_s;
    logic        gated_s;
    logic [1:0]  gate_cnt_s;
    logic        icg_q;

    int checks = 0;
    int errors = 0;

    clk_gate_ctrl #(.IDLE_CYCLES(IDLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES), .STAT_W(16)) dut (
        .clk(clk), .rst(rst), .test_en(test_en), .idle_i(idle_i), .wake_req(wake_req),
        .wake_ack(wake_ack), .gate_en(gate_en), .gated_o(gated_o), .gate_cnt(gate_cnt)
    );

    clk_gate_ctrl #(.IDLE_CYCLES(IDLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES), .STAT_W(2)) dut_s (
        .clk(clk), .rst(rst), .test_en(test_en), .idle_i(idle_i), .wake_req(wake_req),
        .wake_ack(wake_ack_s), .gate_en(gate_en_s), .gated_o(gated_s), .gate_cnt(gate_cnt_s)
    );

    cell_clock_gating u_icg (.CP(clk), .E(gate_en), .TE(test_en), .Q(icg_q));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the clock is off after IDLE_CYCLES+1 consecutive
    // qualifying idle edges; a wake phase lasts WAKE_CYCLES edges.
    bit m_gated, m_ack, m_acked;
    int m_wake, m_streak, m_cnt, m_cnt_s;

    always @(posedge clk) begin : model
        bit fire, g;
        int w, s, c, cs;
        if (rst) begin
            m_gated <= 1'b0; m_ack <= 1'b0; m_acked <= 1'b0;
            m_wake <= 0; m_streak <= 0; m_cnt <= 0; m_cnt_s <= 0;
        end else begin
            g = m_gated; w = m_wake; s = m_streak; c = m_cnt; cs = m_cnt_s;
            fire = !g && (w == 0) && (s == 0) && wake_req && !m_acked;
            if (test_en) begin
                g = 1'b0; w = 0; s = 0;
            end else if (g) begin
                if (wake_req || !idle_i) begin
                    g = 1'b0; w = WAKE_CYCLES;
                end
            end else if (w > 0) begin
                w = w - 1;
            end else if (idle_i && !wake_req) begin
                s = s + 1;
                if (s == IDLE_CYCLES + 1) begin
                    g = 1'b1; s = 0;
                    if (c < 65535) c = c + 1;
                    if (cs < 3) cs = cs + 1;
                end
            end else begin
                s = 0;
            end
            m_gated <= g; m_wake <= w; m_streak <= s; m_cnt <= c; m_cnt_s <= cs;
            m_ack <= fire;
            m_acked <= wake_req && (m_acked || fire);
        end
    end

    task automatic test_reset();
        rst = 1'b1; test_en = 1'b0; idle_i = 1'b1; wake_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (gate_en !== 1'b1 || gated_o !== 1'b0 || gate_cnt !== 16'd0 || wake_ack !== 1'b0 || gate_cnt_s !== 2'd0) begin
            errors++;
            $display("FAIL reset: got en=%b gated=%b cnt=%0d ack=%b cnt_s=%0d expected en=1 gated=0 cnt=0 ack=0 cnt_s=0",
                     gate_en, gated_o, gate_cnt, wake_ack, gate_cnt_s);
        end
        rst = 1'b0; idle_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (icg_q !== 1'b1) begin
            errors++; $display("FAIL reset_icg_running: got %b expected 1", icg_q);
        end
        @(negedge clk);
    endtask

    task automatic test_gating();
        idle_i = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if (gate_en !== (k < 17) || gated_o !== (k >= 17)) begin
                errors++;
                $display("FAIL gating k=%0d: got en=%b gated=%b expected en=%b gated=%b", k, gate_en, gated_o, k < 17, k >= 17);
            end
        end
        checks++;
        if (gate_cnt !== 16'd1) begin
            errors++; $display("FAIL gating_cnt: got %0d expected 1", gate_cnt);
        end
        repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if (icg_q !== 1'b0) begin
                errors++; $display("FAIL gating_icg_flat: got %b expected 0", icg_q);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_idle_glitch();
        idle_i = 1'b0;
        repeat (4) @(negedge clk);
        idle_i = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            checks++;
            if (gate_en !== 1'b1) begin
                errors++; $display("FAIL glitch_pre k=%0d: got en=%b expected 1", k, gate_en);
            end
        end
        idle_i = 1'b0;
        @(negedge clk);
        idle_i = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            checks++;
            if (gate_en !== (k < 17) || gate_cnt !== ((k < 17) ? 16'd1 : 16'd2)) begin
                errors++;
                $display("FAIL glitch_post k=%0d: got en=%b cnt=%0d expected en=%b cnt=%0d", k, gate_en, gate_cnt, k < 17, (k < 17) ? 1 : 2);
            end
        end
    endtask

    task automatic test_wake();
        int acks = 0, ack_k = 0;
        wake_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (gate_en !== 1'b1) begin
                    errors++; $display("FAIL wake_gate_en: got %b expected 1", gate_en);
                end
            end
            if (wake_ack === 1'b1) begin
                acks++; ack_k = k; wake_req = 1'b0;
                checks++;
                if (gated_o !== 1'b0 || gate_en !== 1'b1) begin
                    errors++; $display("FAIL wake_run_state: got gated=%b en=%b expected gated=0 en=1", gated_o, gate_en);
                end
            end
        end
        checks++;
        if (acks != 1 || ack_k != 4) begin
            errors++; $display("FAIL wake_ack: got %0d pulses at cycle %0d expected 1 pulse at cycle 4", acks, ack_k);
        end
        idle_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_handshake();
        int acks, ack_k;
        for (int r = 0; r < 2; r++) begin
            acks = 0; ack_k = 0;
            wake_req = 1'b1;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (wake_ack === 1'b1) begin acks++; ack_k = k; end
            end
            wake_req = 1'b0;
            @(negedge clk);
            checks++;
            if (acks != 1 || ack_k != 1) begin
                errors++; $display("FAIL handshake_run r=%0d: got %0d pulses at cycle %0d expected 1 at cycle 1", r, acks, ack_k);
            end
        end
        idle_i = 1'b1;
        repeat (3) @(negedge clk);
        acks = 0; ack_k = 0;
        wake_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (wake_ack === 1'b1) begin acks++; ack_k = k; end
        end
        checks++;
        if (acks != 1 || ack_k != 2) begin
            errors++; $display("FAIL handshake_count: got %0d pulses at cycle %0d expected 1 at cycle 2", acks, ack_k);
        end
        wake_req = 1'b0;
        repeat (18) @(negedge clk);
        checks++;
        if (gated_o !== 1'b1) begin
            errors++; $display("FAIL handshake_regate: got gated=%b expected 1", gated_o);
        end
        acks = 0;
        wake_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) wake_req = 1'b0;
            if (wake_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++; $display("FAIL handshake_dropped: got %0d pulses expected 0", acks);
        end
        idle_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_test_mode();
        idle_i = 1'b1;
        repeat (18) @(negedge clk);
        checks++;
        if (gated_o !== 1'b1 || gate_en !== 1'b0) begin
            errors++; $display("FAIL testmode_pre: got gated=%b en=%b expected gated=1 en=0", gated_o, gate_en);
        end
        test_en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            checks++;
            if (gate_en !== 1'b1 || gated_o !== 1'b0) begin
                errors++; $display("FAIL testmode_hold k=%0d: got en=%b gated=%b expected en=1 gated=0", k, gate_en, gated_o);
            end
        end
        test_en = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            checks++;
            if (gate_en !== (k < 17)) begin
                errors++; $display("FAIL testmode_exit k=%0d: got en=%b expected %b", k, gate_en, k < 17);
            end
        end
    endtask

    task automatic test_sat_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            idle_i = 1'b0;
            repeat (4) @(negedge clk);
            idle_i = 1'b1;
            repeat (18) @(negedge clk);
            checks++;
            if (gate_cnt_s !== 2'((i < 3) ? i : 3) || gate_cnt !== 16'(i)) begin
                errors++;
                $display("FAIL saturation i=%0d: got cnt_s=%0d cnt=%0d expected cnt_s=%0d cnt=%0d", i, gate_cnt_s, gate_cnt, (i < 3) ? i : 3, i);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (gate_en !== 1'b1 || gated_o !== 1'b0 || gate_cnt !== 16'd0 || gate_cnt_s !== 2'd0 || gate_en_s !== 1'b1) begin
            errors++;
            $display("FAIL reset_while_gated: got en=%b gated=%b cnt=%0d cnt_s=%0d en_s=%b expected 1 0 0 0 1",
                     gate_en, gated_o, gate_cnt, gate_cnt_s, gate_en_s);
        end
    endtask

    task automatic test_random();
        int tm_left = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            checks++;
            if (gate_en !== !m_gated || gated_o !== m_gated || wake_ack !== m_ack || gate_cnt !== 16'(m_cnt) ||
                gate_cnt_s !== 2'(m_cnt_s) || gate_en_s !== !m_gated || wake_ack_s !== m_ack || gated_s !== m_gated) begin
                errors++;
                $display("FAIL random n=%0d: got en=%b gated=%b ack=%b cnt=%0d cnt_s=%0d expected en=%b gated=%b ack=%b cnt=%0d cnt_s=%0d",
                         n, gate_en, gated_o, wake_ack, gate_cnt, gate_cnt_s, !m_gated, m_gated, m_ack, m_cnt, m_cnt_s);
            end
            idle_i = ($urandom_range(0, 15) != 0);
            if (wake_req && wake_ack) wake_req = 1'b0;
            else if (wake_req) wake_req = ($urandom_range(0, 19) != 0);
            else wake_req = ($urandom_range(0, 39) == 0);
            if (tm_left > 0) tm_left--;
            else if ($urandom_range(0, 199) == 0) tm_left = $urandom_range(1, 5);
            test_en = (tm_left > 0);
            rst = ($urandom_range(0, 999) == 0);
        end
        rst = 1'b0; test_en = 1'b0; wake_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_gating();
        test_idle_glitch();
        test_wake();
        test_handshake();
        test_test_mode();
        test_sat_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
